// File: rtl/pending_encoder.sv
// Registered priority encoder with sticky pending bits and a valid/ready output.
// Define PENDING_ENCODER_ROUND_ROBIN_EN for rotating priority after each accept.
module pending_encoder #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req_in,
    input  logic [N-1:0] mask_in,
    input  logic         ready_in,
    output logic [W-1:0] idx_out,
    output logic         valid_out,
    output logic [N-1:0] pend_out,
    output logic         overflow_out
);

    logic [N-1:0] r_pend;
    logic [W-1:0] r_idx;
    logic         r_valid;
    logic         r_ovf;

    logic         w_acc;
    logic         w_load;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pnext;
    logic [N-1:0] w_elig;
    logic [W-1:0] w_sel;

    always_comb begin
        w_acc  = r_valid && ready_in;
        w_load = !r_valid || ready_in;
        w_clr  = '0;
        for (int i = 0; i < N; i++) begin
            w_clr[i] = w_acc && (r_idx == W'(i));
        end
        // set wins over clear for a bit requested while being accepted
        w_pnext = (r_pend & ~w_clr) | req_in;
        w_elig  = w_pnext & ~mask_in;
    end

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] r_last;
    logic [W-1:0] w_ptr;

    // search starts just below the index being accepted this cycle
    always_comb begin
        w_ptr = w_acc ? r_idx : r_last;
        w_sel = '0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = (int'(w_ptr) >= k) ? int'(w_ptr) - k : int'(w_ptr) - k + N;
            if (w_elig[j]) begin
                w_sel = W'(j);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last <= '0;
        end else if (w_acc) begin
            r_last <= r_idx;
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_elig[i]) begin
                w_sel = W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pend  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_pend <= w_pnext;
            r_ovf  <= |(req_in & r_pend & ~w_clr);
            if (w_load) begin
                r_valid <= |w_elig;
                r_idx   <= w_sel;
            end
        end
    end

    assign idx_out      = r_idx;
    assign valid_out    = r_valid;
    assign pend_out     = r_pend;
    assign overflow_out = r_ovf;

endmodule

// File: tb/tb_pending_encoder.sv
// Directed self-checking bench for pending_encoder (N=8 plus an N=5 instance).
module tb_pending_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    logic [4:0] req5;
    logic [4:0] mask5;
    logic       ready5;
    logic [2:0] idx5;
    logic       valid5;
    logic [4:0] pend5;
    logic       ovf5;

    int total;
    int passed;

    pending_encoder #(.N(8)) u_dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .mask_in(mask),
        .ready_in(ready), .idx_out(idx), .valid_out(valid),
        .pend_out(pend), .overflow_out(ovf)
    );

    pending_encoder #(.N(5)) u_dut5 (
        .clk_in(clk), .rst_in(rst), .req_in(req5), .mask_in(mask5),
        .ready_in(ready5), .idx_out(idx5), .valid_out(valid5),
        .pend_out(pend5), .overflow_out(ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; mask = '0; ready = 1'b0;
        req5 = '0; mask5 = '0; ready5 = 1'b0;
        step();
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_pend", pend, 8'h00);
        rst = 1'b0;
        req = 8'hFF;
        step();
        chk("pre_valid", {7'd0, valid}, 8'h01);
        chk("pre_idx", {5'd0, idx}, 8'h07);
        chk("pre_pend", pend, 8'hFF);
        req = 8'h00;
        #3 rst = 1'b1;
        #1;
        chk("async_valid", {7'd0, valid}, 8'h00);
        chk("async_idx", {5'd0, idx}, 8'h00);
        chk("async_pend", pend, 8'h00);
        chk("async_ovf", {7'd0, ovf}, 8'h00);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req = 8'h04; ready = 1'b1;
        step();
        chk("single_valid", {7'd0, valid}, 8'h01);
        chk("single_idx", {5'd0, idx}, 8'h02);
        req = 8'h00;
        step();
        chk("single_pend", pend, 8'h00);
        chk("single_done", {7'd0, valid}, 8'h00);
    endtask

    task automatic test_hold();
        ready = 1'b0; req = 8'h81;
        step();
        chk("hold_idx0", {5'd0, idx}, 8'h07);
        req = 8'h00;
        step();
        chk("hold_idx1", {5'd0, idx}, 8'h07);
        req = 8'h40;
        step();
        chk("hold_nopre", {5'd0, idx}, 8'h07);
        chk("hold_pend", pend, 8'hC1);
        req = 8'h00;
        ready = 1'b1;
        step();
        chk("drain_6", {5'd0, idx}, 8'h06);
        step();
        chk("drain_0", {5'd0, idx}, 8'h00);
        chk("drain_v0", {7'd0, valid}, 8'h01);
        step();
        chk("drain_end", {7'd0, valid}, 8'h00);
    endtask

    task automatic test_overflow();
        ready = 1'b0; req = 8'h08;
        step();
        chk("ovf_first", {7'd0, ovf}, 8'h00);
        step();
        chk("ovf_pulse", {7'd0, ovf}, 8'h01);
        req = 8'h00;
        step();
        chk("ovf_clear", {7'd0, ovf}, 8'h00);
        req = 8'h08; ready = 1'b1;
        step();
        chk("setwin_ovf", {7'd0, ovf}, 8'h00);
        chk("setwin_pend", pend, 8'h08);
        chk("setwin_idx", {5'd0, idx}, 8'h03);
        req = 8'h00;
        step();
        chk("setwin_done", pend, 8'h00);
    endtask

    task automatic test_mask();
        ready = 1'b0; mask = 8'h20; req = 8'h30;
        step();
        chk("mask_idx4", {5'd0, idx}, 8'h04);
        req = 8'h00; ready = 1'b1; mask = 8'h00;
        step();
        chk("mask_idx5", {5'd0, idx}, 8'h05);
        step();
        chk("mask_empty", {7'd0, valid}, 8'h00);
        mask = 8'hFF; req = 8'h03;
        step();
        chk("allmask_v", {7'd0, valid}, 8'h00);
        chk("allmask_p", pend, 8'h03);
        req = 8'h00; mask = 8'h00;
        step();
        chk("unmask_v", {7'd0, valid}, 8'h01);
        chk("unmask_idx", {5'd0, idx}, 8'h01);
        step();
        chk("unmask_idx0", {5'd0, idx}, 8'h00);
        step();
        chk("unmask_end", {7'd0, valid}, 8'h00);
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1; req = 8'h0E;
        step();
        chk("b2b_3", {5'd0, idx}, 8'h03);
        req = 8'h00;
        step();
        chk("b2b_2", {5'd0, idx}, 8'h02);
        step();
        chk("b2b_1", {5'd0, idx}, 8'h01);
        step();
        chk("b2b_end", {7'd0, valid}, 8'h00);
    endtask

    task automatic test_fairness();
        logic [7:0] exp;
        do_reset();
        ready = 1'b1; req = 8'h81;
        for (int c = 0; c < 4; c++) begin
            step();
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
            exp = (c % 2 == 0) ? 8'h07 : 8'h00;
`else
            exp = 8'h07;
`endif
            chk("fair_idx", {5'd0, idx}, exp);
        end
        req = 8'h00; ready = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic test_npow2();
        do_reset();
        ready5 = 1'b1; req5 = 5'h11;
        step();
        chk("n5_idx4", {5'd0, idx5}, 8'h04);
        req5 = 5'h00;
        step();
        chk("n5_idx0", {5'd0, idx5}, 8'h00);
        step();
        chk("n5_end", {7'd0, valid5}, 8'h00);
        chk("n5_pend", {3'd0, pend5}, 8'h00);
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_single();
        test_hold();
        test_overflow();
        test_mask();
        test_back_to_back();
        test_fairness();
        test_npow2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
